// File: rtl/delta_outlier_encoder_if.sv
// Stream bundle for delta_outlier_encoder: activation input, inlier stream, outlier FIFO
// head and per-vector status.
interface delta_outlier_encoder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned M      = 4,
  parameter int unsigned IDX_W  = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     inl_valid;
  logic                     inl_ready;
  logic signed [M-1:0]      inl_data;
  logic                     inl_is_outlier;
  logic [IDX_W-1:0]         inl_idx;
  logic                     inl_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_idx;
  logic signed [DATA_W:0]   out_delta;
  logic                     vec_done;
  logic [IDX_W:0]           outlier_cnt;
  logic                     len_err;

  modport master (
    output in_valid, in_data, in_last, inl_ready, out_ready,
    input  in_ready, inl_valid, inl_data, inl_is_outlier, inl_idx, inl_last,
           out_valid, out_idx, out_delta, vec_done, outlier_cnt, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, inl_ready, out_ready,
    output in_ready, inl_valid, inl_data, inl_is_outlier, inl_idx, inl_last,
           out_valid, out_idx, out_delta, vec_done, outlier_cnt, len_err
  );
endinterface

// File: rtl/delta_outlier_encoder.sv
// Temporal-delta encoder: small deltas go out as M-bit codes on the inlier stream, large
// ones are queued with their index in a first-word-fall-through outlier FIFO.
module delta_outlier_encoder #(
  parameter int unsigned VEC_LEN     = 128,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned M           = 4,
  parameter int unsigned THRESHOLD   = 7,
  parameter int unsigned OFIFO_DEPTH = 16,
  parameter int unsigned IDX_W       = $clog2(VEC_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  delta_outlier_encoder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(OFIFO_DEPTH);
  localparam logic signed [DATA_W:0] ThrPos = (DATA_W+1)'(THRESHOLD);
  localparam logic signed [DATA_W:0] ThrNeg = -ThrPos;

  logic signed [DATA_W-1:0] r_prev [VEC_LEN];
  logic [IDX_W-1:0]         r_idx;
  logic                     r_first_vec;
  logic                     r_len_err;
  logic                     r_vec_done;
  logic [IDX_W:0]           r_ocnt;
  logic [IDX_W:0]           r_outlier_cnt;

  logic                     r_inl_valid;
  logic signed [M-1:0]      r_inl_data;
  logic                     r_inl_is_outlier;
  logic [IDX_W-1:0]         r_inl_idx;
  logic                     r_inl_last;

  logic [IDX_W-1:0]         r_fifo_idx   [OFIFO_DEPTH];
  logic signed [DATA_W:0]   r_fifo_delta [OFIFO_DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [PTR_W:0]           r_count;

  logic                     w_in_ready;
  logic                     w_acc;
  logic signed [DATA_W-1:0] w_prev;
  logic signed [DATA_W:0]   w_delta;
  logic                     w_outlier;
  logic                     w_last_idx;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_out_valid;
  logic [IDX_W:0]           w_ocnt_next;

  // rst_n gates in_ready so nothing is accepted while reset is asserted.
  assign w_in_ready  = rst_n && (!r_inl_valid || bus.inl_ready) &&
                       (r_count < (PTR_W+1)'(OFIFO_DEPTH));
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_prev      = r_first_vec ? '0 : r_prev[r_idx];
  assign w_delta     = {bus.in_data[DATA_W-1], bus.in_data} - {w_prev[DATA_W-1], w_prev};
  assign w_outlier   = !((w_delta >= ThrNeg) && (w_delta <= ThrPos));
  assign w_last_idx  = (r_idx == IDX_W'(VEC_LEN - 1));
  assign w_push      = w_acc && w_outlier;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = bus.out_ready && w_out_valid;
  assign w_ocnt_next = r_ocnt + (IDX_W+1)'(w_outlier);

  // Previous-vector buffer is deliberately unreset; first_vec masks its contents.
  always_ff @(posedge clk) begin
    if (w_acc) r_prev[r_idx] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wptr]   <= r_idx;
      r_fifo_delta[r_wptr] <= w_delta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_first_vec   <= 1'b1;
      r_len_err     <= 1'b0;
      r_vec_done    <= 1'b0;
      r_ocnt        <= '0;
      r_outlier_cnt <= '0;
    end else begin
      r_vec_done <= w_acc && bus.in_last;
      if (w_acc) begin
        r_idx <= (bus.in_last || w_last_idx) ? '0 : r_idx + IDX_W'(1);
        if (bus.in_last) begin
          r_first_vec   <= 1'b0;
          r_outlier_cnt <= w_ocnt_next;
          r_ocnt        <= '0;
        end else begin
          r_ocnt <= w_ocnt_next;
        end
        if (bus.in_last != w_last_idx) r_len_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inl_valid      <= 1'b0;
      r_inl_data       <= '0;
      r_inl_is_outlier <= 1'b0;
      r_inl_idx        <= '0;
      r_inl_last       <= 1'b0;
    end else if (w_acc) begin
      r_inl_valid      <= 1'b1;
      r_inl_data       <= w_outlier ? '0 : w_delta[M-1:0];
      r_inl_is_outlier <= w_outlier;
      r_inl_idx        <= r_idx;
      r_inl_last       <= bus.in_last;
    end else if (bus.inl_ready) begin
      r_inl_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.inl_valid      = r_inl_valid;
  assign bus.inl_data       = r_inl_data;
  assign bus.inl_is_outlier = r_inl_is_outlier;
  assign bus.inl_idx        = r_inl_idx;
  assign bus.inl_last       = r_inl_last;
  // Head fields read as zero when empty so stale memory never shows on the port.
  assign bus.out_valid      = w_out_valid;
  assign bus.out_idx        = w_out_valid ? r_fifo_idx[r_rptr] : '0;
  assign bus.out_delta      = w_out_valid ? r_fifo_delta[r_rptr] : '0;
  assign bus.vec_done       = r_vec_done;
  assign bus.outlier_cnt    = r_outlier_cnt;
  assign bus.len_err        = r_len_err;
endmodule

// File: tb/tb_delta_outlier_encoder.sv
// Directed bench for delta_outlier_encoder: hand-computed vectors plus a small reference
// model for the randomly stalled stream.
module tb_delta_outlier_encoder;
  localparam int VL = 128;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int IW = 7;

  typedef struct packed {logic oh; logic [3:0] data; logic [6:0] idx; logic last;} inl_t;
  typedef struct packed {logic [6:0] idx; logic [16:0] delta;} out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delta_outlier_encoder_if #(.DATA_W(DW), .M(MW), .IDX_W(IW)) bus ();

  delta_outlier_encoder #(
    .VEC_LEN(VL), .DATA_W(DW), .M(MW), .THRESHOLD(7), .OFIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_err = 0;
  logic [7:0] last_ocnt = '0;
  inl_t act_inl[$], exp_inl[$];
  out_t act_out[$], exp_out[$];
  logic signed [15:0] mprev [VL];
  bit mfirst = 1'b1;
  int midx = 0;
  bit rand_rdy = 1'b0, inl_rdy_set = 1'b1, out_rdy_set = 1'b1;
  inl_t mon_cur, mon_held;
  bit mon_stalled = 1'b0;

  // Ready drivers change just after the rising edge.
  initial begin
    bus.inl_ready = 1'b1;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        bus.inl_ready = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.inl_ready = inl_rdy_set;
        bus.out_ready = out_rdy_set;
      end
    end
  end

  // Monitor samples on the falling edge: handshakes seen here complete at the next rise.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_stalled = 1'b0;
      end else begin
        mon_cur = {bus.inl_is_outlier, bus.inl_data, bus.inl_idx, bus.inl_last};
        if (mon_stalled && (!bus.inl_valid || mon_cur !== mon_held)) stall_err++;
        if (bus.inl_valid && bus.inl_ready) act_inl.push_back(mon_cur);
        mon_stalled = bus.inl_valid && !bus.inl_ready;
        mon_held = mon_cur;
        if (bus.out_valid && bus.out_ready) act_out.push_back({bus.out_idx, bus.out_delta});
        if (bus.vec_done) begin
          done_cnt++;
          last_ocnt = bus.outlier_cnt;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  task automatic clear_q();
    act_inl.delete(); exp_inl.delete(); act_out.delete(); exp_out.delete();
  endtask

  task automatic send_elem(input logic signed [15:0] d, input bit last, input int budget);
    bit ok;
    logic signed [15:0] p;
    logic signed [16:0] dl;
    ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept idx=%0d: in_ready stayed 0 for %0d cycles, want 1", midx, budget);
    end else begin
      p = mfirst ? 16'sd0 : mprev[midx];
      dl = {d[15], d} - {p[15], p};
      if (dl >= -7 && dl <= 7) exp_inl.push_back({1'b0, dl[3:0], 7'(midx), last});
      else begin
        exp_inl.push_back({1'b1, 4'b0, 7'(midx), last});
        exp_out.push_back({7'(midx), dl});
      end
      mprev[midx] = d;
      if (last) mfirst = 1'b0;
      midx = (last || midx == VL - 1) ? 0 : midx + 1;
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!bus.inl_valid && !bus.out_valid) begin idle = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!idle) begin errors++; $display("FAIL drain: streams still busy, want idle"); end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks += 10;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    if (bus.inl_valid !== 1'b0) begin errors++; $display("FAIL rst_inl_valid got %b want 0", bus.inl_valid); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    if (bus.vec_done !== 1'b0) begin errors++; $display("FAIL rst_vec_done got %b want 0", bus.vec_done); end
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got %b want 0", bus.len_err); end
    if (bus.outlier_cnt !== 8'd0) begin errors++; $display("FAIL rst_ocnt got %0d want 0", bus.outlier_cnt); end
    if (bus.inl_data !== 4'd0) begin errors++; $display("FAIL rst_inl_data got %h want 0", bus.inl_data); end
    if (bus.inl_idx !== 7'd0) begin errors++; $display("FAIL rst_inl_idx got %0d want 0", bus.inl_idx); end
    if (bus.inl_last !== 1'b0) begin errors++; $display("FAIL rst_inl_last got %b want 0", bus.inl_last); end
    if (bus.inl_is_outlier !== 1'b0) begin errors++; $display("FAIL rst_inl_oh got %b want 0", bus.inl_is_outlier); end
    @(negedge clk); rst_n = 1'b1;
    mfirst = 1'b1; midx = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_first_vector();
    int d0;
    inl_t e;
    clear_q(); d0 = done_cnt;
    for (int i = 0; i < VL; i++) send_elem(16'(i), i == VL - 1, 4);
    wait_idle();
    checks += 5;
    if (act_inl.size() != 128) begin errors++; $display("FAIL v1_inl_beats got %0d want 128", act_inl.size()); end
    if (act_out.size() != 120) begin errors++; $display("FAIL v1_out_entries got %0d want 120", act_out.size()); end
    if (last_ocnt !== 8'd120) begin errors++; $display("FAIL v1_ocnt got %0d want 120", last_ocnt); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL v1_vec_done got %0d pulses want 1", done_cnt - d0); end
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL v1_len_err got %b want 0", bus.len_err); end
    for (int i = 0; i < act_inl.size() && i < 128; i++) begin
      e.oh = (i > 7); e.data = (i > 7) ? 4'd0 : 4'(i); e.idx = 7'(i); e.last = (i == 127);
      checks++;
      if (act_inl[i] !== e) begin errors++; $display("FAIL v1_inl[%0d] got %h want %h", i, act_inl[i], e); end
    end
    for (int i = 0; i < act_out.size() && i < 120; i++) begin
      checks++;
      if (act_out[i] !== {7'(i + 8), 17'(i + 8)}) begin
        errors++; $display("FAIL v1_out[%0d] got %h want idx %0d delta %0d", i, act_out[i], i + 8, i + 8);
      end
    end
  endtask

  task automatic test_second_vector();
    clear_q();
    for (int i = 0; i < VL; i++) send_elem(16'(i), i == VL - 1, 4);
    wait_idle();
    checks += 3;
    if (act_inl.size() != 128) begin errors++; $display("FAIL v2_inl_beats got %0d want 128", act_inl.size()); end
    if (act_out.size() != 0) begin errors++; $display("FAIL v2_out_entries got %0d want 0", act_out.size()); end
    if (last_ocnt !== 8'd0) begin errors++; $display("FAIL v2_ocnt got %0d want 0", last_ocnt); end
    for (int i = 0; i < act_inl.size() && i < 128; i++) begin
      checks++;
      if (act_inl[i] !== {1'b0, 4'd0, 7'(i), i == 127}) begin
        errors++; $display("FAIL v2_inl[%0d] got %h want zero inlier", i, act_inl[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic signed [15:0] d;
    clear_q();
    for (int i = 0; i < VL; i++) begin
      case (i)
        0: d = -16'sd7;  1: d = 16'sd8;  2: d = -16'sd6;  3: d = 16'sd11;
        4: d = 16'sd32767;
        default: d = 16'(i);
      endcase
      send_elem(d, i == VL - 1, 4);
    end
    wait_idle();
    checks += 9;
    if (act_inl[0] !== {1'b0, 4'b1001, 7'd0, 1'b0}) begin errors++; $display("FAIL bnd_m7 got %h want code 1001", act_inl[0]); end
    if (act_inl[1] !== {1'b0, 4'b0111, 7'd1, 1'b0}) begin errors++; $display("FAIL bnd_p7 got %h want code 0111", act_inl[1]); end
    if (act_inl[2] !== {1'b1, 4'b0000, 7'd2, 1'b0}) begin errors++; $display("FAIL bnd_m8_inl got %h want outlier", act_inl[2]); end
    if (act_inl[3] !== {1'b1, 4'b0000, 7'd3, 1'b0}) begin errors++; $display("FAIL bnd_p8_inl got %h want outlier", act_inl[3]); end
    if (act_out.size() != 3) begin errors++; $display("FAIL bnd_out_entries got %0d want 3", act_out.size()); end
    if (act_out[0] !== {7'd2, 17'h1FFF8}) begin errors++; $display("FAIL bnd_out_m8 got %h want idx 2 delta -8", act_out[0]); end
    if (act_out[1] !== {7'd3, 17'h00008}) begin errors++; $display("FAIL bnd_out_p8 got %h want idx 3 delta 8", act_out[1]); end
    if (act_out[2] !== {7'd4, 17'h07FFB}) begin errors++; $display("FAIL bnd_out_big got %h want idx 4 delta 32763", act_out[2]); end
    if (last_ocnt !== 8'd3) begin errors++; $display("FAIL bnd_ocnt got %0d want 3", last_ocnt); end
    // Same vector again except element 4 swings from 32767 to -32768.
    clear_q();
    for (int i = 0; i < VL; i++) begin
      d = (i == 4) ? -16'sd32768 : mprev[i];
      send_elem(d, i == VL - 1, 4);
    end
    wait_idle();
    checks += 4;
    if (act_out.size() != 1) begin errors++; $display("FAIL wrap_out_entries got %0d want 1", act_out.size()); end
    if (act_out[0] !== {7'd4, 17'h10001}) begin errors++; $display("FAIL wrap_delta got %h want idx 4 delta -65535", act_out[0]); end
    if (last_ocnt !== 8'd1) begin errors++; $display("FAIL wrap_ocnt got %0d want 1", last_ocnt); end
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL wrap_len_err got %b want 0", bus.len_err); end
  endtask

  task automatic test_fifo_full();
    clear_q();
    out_rdy_set = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 16; i++) send_elem(16'(int'(mprev[i]) + 100), 1'b0, 1);
    bus.in_valid = 1'b1; bus.in_data = 16'(int'(mprev[16]) + 100); bus.in_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready cyc %0d got %b want 0", c, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %b want 1", bus.out_valid); end
    if (act_out.size() != 0) begin errors++; $display("FAIL full_popped got %0d want 0", act_out.size()); end
    out_rdy_set = 1'b1;
    for (int i = 16; i < 20; i++) send_elem(16'(int'(mprev[i]) + 100), 1'b0, 8);
    for (int i = 20; i < VL; i++) send_elem(mprev[i], i == VL - 1, 8);
    wait_idle();
    checks += 3;
    if (act_out.size() != 20) begin errors++; $display("FAIL full_out_entries got %0d want 20", act_out.size()); end
    if (act_inl.size() != 128) begin errors++; $display("FAIL full_inl_beats got %0d want 128", act_inl.size()); end
    if (last_ocnt !== 8'd20) begin errors++; $display("FAIL full_ocnt got %0d want 20", last_ocnt); end
    for (int i = 0; i < act_out.size() && i < 20; i++) begin
      checks++;
      if (act_out[i] !== {7'(i), 17'd100}) begin
        errors++; $display("FAIL full_out[%0d] got %h want idx %0d delta 100", i, act_out[i], i);
      end
    end
  endtask

  task automatic test_random_stalls();
    int d0, s0;
    clear_q(); d0 = done_cnt; s0 = stall_err;
    rand_rdy = 1'b1;
    for (int v = 0; v < 10; v++)
      for (int i = 0; i < VL; i++)
        send_elem(16'(int'(mprev[i]) + int'($urandom_range(0, 40)) - 20), i == VL - 1, 64);
    rand_rdy = 1'b0;
    wait_idle();
    checks += 5;
    if (act_inl.size() != 1280) begin errors++; $display("FAIL rnd_inl_beats got %0d want 1280", act_inl.size()); end
    if (act_out.size() != exp_out.size()) begin errors++; $display("FAIL rnd_out_entries got %0d want %0d", act_out.size(), exp_out.size()); end
    if (stall_err != s0) begin errors++; $display("FAIL rnd_stall_hold got %0d changes want 0", stall_err - s0); end
    if (done_cnt - d0 != 10) begin errors++; $display("FAIL rnd_vec_done got %0d want 10", done_cnt - d0); end
    if (exp_inl.size() != 1280) begin errors++; $display("FAIL rnd_sent got %0d want 1280", exp_inl.size()); end
    for (int i = 0; i < act_inl.size() && i < exp_inl.size(); i++) begin
      checks++;
      if (act_inl[i] !== exp_inl[i]) begin errors++; $display("FAIL rnd_inl[%0d] got %h want %h", i, act_inl[i], exp_inl[i]); end
    end
    for (int i = 0; i < act_out.size() && i < exp_out.size(); i++) begin
      checks++;
      if (act_out[i] !== exp_out[i]) begin errors++; $display("FAIL rnd_out[%0d] got %h want %h", i, act_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    out_rdy_set = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 50; i++) send_elem((i < 10) ? 16'(int'(mprev[i]) + 1000) : mprev[i], 1'b0, 4);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_out_valid got %b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks += 8;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", bus.in_ready); end
    if (bus.inl_valid !== 1'b0) begin errors++; $display("FAIL mid_inl_valid got %b want 0", bus.inl_valid); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_idx !== 7'd0 || bus.out_delta !== 17'd0) begin errors++; $display("FAIL mid_out_head got %h/%h want 0", bus.out_idx, bus.out_delta); end
    if (bus.inl_idx !== 7'd0 || bus.inl_data !== 4'd0) begin errors++; $display("FAIL mid_inl_fields got %h/%h want 0", bus.inl_idx, bus.inl_data); end
    if (bus.inl_is_outlier !== 1'b0 || bus.inl_last !== 1'b0) begin errors++; $display("FAIL mid_inl_flags got %b%b want 00", bus.inl_is_outlier, bus.inl_last); end
    if (bus.outlier_cnt !== 8'd0) begin errors++; $display("FAIL mid_ocnt got %0d want 0", bus.outlier_cnt); end
    if (bus.vec_done !== 1'b0 || bus.len_err !== 1'b0) begin errors++; $display("FAIL mid_status got %b%b want 00", bus.vec_done, bus.len_err); end
    @(negedge clk); rst_n = 1'b1;
    mfirst = 1'b1; midx = 0; out_rdy_set = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_empty got %b want 0", bus.out_valid); end
    clear_q();
    for (int i = 0; i < VL; i++) send_elem(16'(3 * i - 100), i == VL - 1, 8);
    wait_idle();
    checks += 5;
    if (act_inl[33] !== {1'b0, 4'hF, 7'd33, 1'b0}) begin errors++; $display("FAIL mid_inl33 got %h want code F", act_inl[33]); end
    if (act_inl[35] !== {1'b0, 4'h5, 7'd35, 1'b0}) begin errors++; $display("FAIL mid_inl35 got %h want code 5", act_inl[35]); end
    if (act_out[0] !== {7'd0, 17'h1FF9C}) begin errors++; $display("FAIL mid_out0 got %h want idx 0 delta -100", act_out[0]); end
    if (act_out.size() != 123) begin errors++; $display("FAIL mid_out_entries got %0d want 123", act_out.size()); end
    if (last_ocnt !== 8'd123) begin errors++; $display("FAIL mid_ocnt got %0d want 123", last_ocnt); end
  endtask

  task automatic test_len_err();
    clear_q();
    for (int i = 0; i < 100; i++) send_elem(mprev[i], i == 99, 4);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL len_set got %b want 1", bus.len_err); end
    for (int i = 0; i < VL; i++) send_elem(mprev[i], i == VL - 1, 4);
    wait_idle();
    checks += 4;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL len_sticky got %b want 1", bus.len_err); end
    if (act_inl.size() != 228) begin errors++; $display("FAIL len_beats got %0d want 228", act_inl.size()); end
    if (act_inl[99].last !== 1'b1 || act_inl[99].idx !== 7'd99) begin errors++; $display("FAIL len_short_last got %h want idx 99 last", act_inl[99]); end
    if (act_inl[100].idx !== 7'd0) begin errors++; $display("FAIL len_next_idx got %0d want 0", act_inl[100].idx); end
  endtask

  initial begin
    test_reset();
    test_first_vector();
    test_second_vector();
    test_boundary();
    test_fifo_full();
    test_random_stalls();
    test_reset_mid();
    test_len_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
